// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_pkg;

  // Instruction memory map.
  localparam logic [31:0] IM_RESET_ADDRESS = 32'h0000_3000;
  localparam logic [31:0] IM_BASE_ADDRESS  = 32'h0000_3000;
  localparam logic [31:0] IM_END_ADDRESS   = 32'h0000_6FFC;

  // Address error on instruction fetch.
  localparam logic [4:0] EXC_ADEL = 5'd4;

  // Fetch FSM state encodings.
  typedef enum logic [0:0] {
    FETCH_S_FETCH = 1'b0,
    FETCH_S_HOLD  = 1'b1
  } fetch_state_e;

  // One fetched instruction together with its tags.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        exc;
    logic [4:0]  exccode;
  } fetch_pkt_t;

  // True when a fetch from this PC must raise an address error.
  function automatic logic is_bad_fetch_addr(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < IM_BASE_ADDRESS) || (pc > IM_END_ADDRESS);
  endfunction

endpackage

// File: rtl/fetch_ifid_reg.sv
// IF/ID pipeline register: flush beats load beats bubble; otherwise holds.
module fetch_ifid_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        bubble,
  input  logic        flush,
  input  logic        bd_in,
  input  fetch_pkt_t  pkt_in,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        bd,
  output logic        exc,
  output logic [4:0]  exccode
);

  logic        valid_q;
  logic        bd_q;
  fetch_pkt_t  pkt_q;

  // Register update; a bubble only clears valid so the stale fields stay put.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      bd_q    <= 1'b0;
      pkt_q   <= '0;
    end else if (flush) begin
      valid_q   <= 1'b0;
      bd_q      <= 1'b0;
      pkt_q.exc <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      bd_q    <= bd_in;
      pkt_q   <= pkt_in;
    end else if (bubble) begin
      valid_q <= 1'b0;
    end
  end

  assign valid   = valid_q;
  assign bd      = bd_q;
  assign instr   = pkt_q.instr;
  assign pc      = pkt_q.pc;
  assign exc     = pkt_q.exc;
  assign exccode = pkt_q.exccode;

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: PC register, IM request FSM, hold buffer and IF/ID register.
module fetch
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] next_pc,
  input  logic        id_stall,
  input  logic        id_flush,
  input  logic        branch_in_id,
  output logic [31:0] im_addr,
  output logic        im_req,
  input  logic [31:0] im_rdata,
  input  logic        im_ready,
  output logic [31:0] curr_pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic        ifid_bd,
  output logic        ifid_exc,
  output logic [4:0]  ifid_exccode
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  fetch_pkt_t   hold_q;
  fetch_pkt_t   fetched;
  fetch_pkt_t   load_pkt;
  logic         bad_addr;
  logic         hold_en;
  logic         ifid_load;
  logic         ifid_bubble;
  logic         ifid_flush;

  // Address check and the packet produced by the current fetch.
  always_comb begin
    bad_addr = is_bad_fetch_addr(pc_q);
    fetched  = '0;
    fetched.pc = pc_q;
    if (bad_addr) begin
      // Bad addresses complete at once as a nop carrying an address error.
      fetched.instr   = 32'h0;
      fetched.exc     = 1'b1;
      fetched.exccode = EXC_ADEL;
    end else begin
      fetched.instr   = im_rdata;
      fetched.exc     = 1'b0;
      fetched.exccode = 5'd0;
    end
  end

  // Next-state, PC advance and IF/ID control decode.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    im_req      = 1'b0;
    hold_en     = 1'b0;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    ifid_flush  = 1'b0;
    load_pkt    = fetched;

    if (state_q == FETCH_S_FETCH) begin
      im_req = !bad_addr;
    end

    if (id_flush) begin
      // Flush overrides everything, including a response arriving this cycle.
      ifid_flush = 1'b1;
      pc_d       = next_pc;
      state_d    = FETCH_S_FETCH;
    end else begin
      unique case (state_q)
        FETCH_S_FETCH: begin
          if (im_ready || bad_addr) begin
            if (!id_stall) begin
              ifid_load = 1'b1;
              pc_d      = next_pc;
            end else begin
              hold_en = 1'b1;
              state_d = FETCH_S_HOLD;
            end
          end else if (!id_stall) begin
            ifid_bubble = 1'b1;
          end
        end
        FETCH_S_HOLD: begin
          load_pkt = hold_q;
          if (!id_stall) begin
            ifid_load = 1'b1;
            pc_d      = next_pc;
            state_d   = FETCH_S_FETCH;
          end
        end
        default: begin
          state_d = FETCH_S_FETCH;
        end
      endcase
    end
  end

  // FSM state and PC register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH_S_FETCH;
      pc_q    <= IM_RESET_ADDRESS;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Hold buffer keeps a completed fetch while decode is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q <= '0;
    end else if (hold_en) begin
      hold_q <= fetched;
    end
  end

  fetch_ifid_reg u_ifid_reg (
    .clk     (clk),
    .reset   (reset),
    .load    (ifid_load),
    .bubble  (ifid_bubble),
    .flush   (ifid_flush),
    .bd_in   (branch_in_id),
    .pkt_in  (load_pkt),
    .valid   (ifid_valid),
    .instr   (ifid_instr),
    .pc      (ifid_pc),
    .bd      (ifid_bd),
    .exc     (ifid_exc),
    .exccode (ifid_exccode)
  );

  assign im_addr = pc_q;
  assign curr_pc = pc_q;

endmodule

// File: tb/tb_fetch.sv
// Directed table-driven bench for the fetch stage.
module tb_fetch;

  logic        clk;
  logic        reset;
  logic [31:0] next_pc;
  logic        id_stall;
  logic        id_flush;
  logic        branch_in_id;
  logic [31:0] im_addr;
  logic        im_req;
  logic [31:0] im_rdata;
  logic        im_ready;
  logic [31:0] curr_pc;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic        ifid_bd;
  logic        ifid_exc;
  logic [4:0]  ifid_exccode;

  int total;
  int bad;

  fetch dut (
    .clk          (clk),
    .reset        (reset),
    .next_pc      (next_pc),
    .id_stall     (id_stall),
    .id_flush     (id_flush),
    .branch_in_id (branch_in_id),
    .im_addr      (im_addr),
    .im_req       (im_req),
    .im_rdata     (im_rdata),
    .im_ready     (im_ready),
    .curr_pc      (curr_pc),
    .ifid_valid   (ifid_valid),
    .ifid_instr   (ifid_instr),
    .ifid_pc      (ifid_pc),
    .ifid_bd      (ifid_bd),
    .ifid_exc     (ifid_exc),
    .ifid_exccode (ifid_exccode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] nxt;
    logic        stall;
    logic        flush;
    logic        bid;
    logic        ready;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [31:0] e_ifpc;
    logic [31:0] e_instr;
    logic        e_bd;
    logic        e_exc;
    logic [4:0]  e_code;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic [31:0] nxt, input logic stall, input logic flush,
                              input logic bid, input logic ready, input logic [31:0] rdata,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic [31:0] e_pc, input logic e_valid,
                              input logic [31:0] e_ifpc, input logic [31:0] e_instr,
                              input logic e_bd, input logic e_exc, input logic [4:0] e_code);
    vec_t v;
    v.nxt = nxt; v.stall = stall; v.flush = flush; v.bid = bid; v.ready = ready;
    v.rdata = rdata; v.e_req = e_req; v.e_addr = e_addr; v.e_pc = e_pc;
    v.e_valid = e_valid; v.e_ifpc = e_ifpc; v.e_instr = e_instr; v.e_bd = e_bd;
    v.e_exc = e_exc; v.e_code = e_code;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s [%0d]: got %h want %h", name, idx, act, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    next_pc = 32'h0; id_stall = 1'b0; id_flush = 1'b0; branch_in_id = 1'b0;
    im_rdata = 32'h0; im_ready = 1'b0;

    //           nxt       stl flu bid rdy rdata          req addr      pc        vld ifpc      instr     bd exc code
    vecs[0]  = mk(32'h3004, 0, 0, 0, 1, 32'h2408_0001, 1, 32'h3000, 32'h3004, 1, 32'h3000, 32'h2408_0001, 0, 0, 0);
    vecs[1]  = mk(32'hDEAD, 0, 0, 0, 0, 32'h0,         1, 32'h3004, 32'h3004, 0, 32'h3000, 32'h2408_0001, 0, 0, 0);
    vecs[2]  = mk(32'hBEEF, 0, 0, 0, 0, 32'h0,         1, 32'h3004, 32'h3004, 0, 32'h3000, 32'h2408_0001, 0, 0, 0);
    vecs[3]  = mk(32'h3008, 0, 0, 0, 1, 32'h8C09_0010, 1, 32'h3004, 32'h3008, 1, 32'h3004, 32'h8C09_0010, 0, 0, 0);
    vecs[4]  = mk(32'h5000, 1, 0, 0, 1, 32'h0109_5020, 1, 32'h3008, 32'h3008, 1, 32'h3004, 32'h8C09_0010, 0, 0, 0);
    vecs[5]  = mk(32'h5000, 1, 0, 0, 1, 32'hFFFF_0000, 0, 32'h3008, 32'h3008, 1, 32'h3004, 32'h8C09_0010, 0, 0, 0);
    vecs[6]  = mk(32'h5000, 1, 0, 0, 1, 32'hFFFF_0000, 0, 32'h3008, 32'h3008, 1, 32'h3004, 32'h8C09_0010, 0, 0, 0);
    vecs[7]  = mk(32'h300C, 0, 0, 1, 0, 32'h0,         0, 32'h3008, 32'h300C, 1, 32'h3008, 32'h0109_5020, 1, 0, 0);
    vecs[8]  = mk(32'h3002, 0, 0, 0, 1, 32'h1000_FFFF, 1, 32'h300C, 32'h3002, 1, 32'h300C, 32'h1000_FFFF, 0, 0, 0);
    vecs[9]  = mk(32'h7000, 0, 0, 0, 1, 32'h5555_5555, 0, 32'h3002, 32'h7000, 1, 32'h3002, 32'h0,         0, 1, 4);
    vecs[10] = mk(32'h3010, 0, 0, 0, 0, 32'h0,         0, 32'h7000, 32'h3010, 1, 32'h7000, 32'h0,         0, 1, 4);
    vecs[11] = mk(32'h6000, 1, 0, 0, 1, 32'hAAAA_5555, 1, 32'h3010, 32'h3010, 1, 32'h7000, 32'h0,         0, 1, 4);
    vecs[12] = mk(32'h4180, 1, 1, 1, 1, 32'h0,         0, 32'h3010, 32'h4180, 0, 32'h7000, 32'h0,         0, 0, 4);
    vecs[13] = mk(32'h4184, 0, 0, 0, 1, 32'h1234_5678, 1, 32'h4180, 32'h4184, 1, 32'h4180, 32'h1234_5678, 0, 0, 0);
    vecs[14] = mk(32'h3000, 0, 1, 0, 1, 32'hFFFF_FFFF, 1, 32'h4184, 32'h3000, 0, 32'h4180, 32'h1234_5678, 0, 0, 0);
    vecs[15] = mk(32'h6FFC, 0, 0, 0, 1, 32'h1111_1111, 1, 32'h3000, 32'h6FFC, 1, 32'h3000, 32'h1111_1111, 0, 0, 0);
    vecs[16] = mk(32'h2FFC, 0, 0, 0, 1, 32'h2222_2222, 1, 32'h6FFC, 32'h2FFC, 1, 32'h6FFC, 32'h2222_2222, 0, 0, 0);
    vecs[17] = mk(32'h3000, 0, 0, 0, 1, 32'h3333_3333, 0, 32'h2FFC, 32'h3000, 1, 32'h2FFC, 32'h0,         0, 1, 4);

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_curr_pc", -1, curr_pc, 32'h3000);
    chk("rst_im_req", -1, {31'h0, im_req}, 32'h1);
    chk("rst_ifid_valid", -1, {31'h0, ifid_valid}, 32'h0);
    chk("rst_ifid_pc", -1, ifid_pc, 32'h0);
    chk("rst_ifid_instr", -1, ifid_instr, 32'h0);
    chk("rst_ifid_exc", -1, {31'h0, ifid_exc}, 32'h0);

    for (int i = 0; i < NV; i++) begin
      next_pc      = vecs[i].nxt;
      id_stall     = vecs[i].stall;
      id_flush     = vecs[i].flush;
      branch_in_id = vecs[i].bid;
      im_ready     = vecs[i].ready;
      im_rdata     = vecs[i].rdata;
      #1;
      chk("im_req", i, {31'h0, im_req}, {31'h0, vecs[i].e_req});
      chk("im_addr", i, im_addr, vecs[i].e_addr);
      @(posedge clk);
      #1;
      chk("curr_pc", i, curr_pc, vecs[i].e_pc);
      chk("ifid_valid", i, {31'h0, ifid_valid}, {31'h0, vecs[i].e_valid});
      chk("ifid_pc", i, ifid_pc, vecs[i].e_ifpc);
      chk("ifid_instr", i, ifid_instr, vecs[i].e_instr);
      chk("ifid_bd", i, {31'h0, ifid_bd}, {31'h0, vecs[i].e_bd});
      chk("ifid_exc", i, {31'h0, ifid_exc}, {31'h0, vecs[i].e_exc});
      chk("ifid_exccode", i, {27'h0, ifid_exccode}, {27'h0, vecs[i].e_code});
      @(negedge clk);
    end

    // Advance once, then assert reset asynchronously while a fetch is waiting.
    id_stall = 1'b0; id_flush = 1'b0; branch_in_id = 1'b1;
    next_pc = 32'h3004; im_ready = 1'b1; im_rdata = 32'hCAFE_0001;
    @(posedge clk);
    #1;
    chk("pre_rst_ifid_valid", 100, {31'h0, ifid_valid}, 32'h1);
    chk("pre_rst_curr_pc", 100, curr_pc, 32'h3004);
    @(negedge clk);
    im_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_curr_pc", 101, curr_pc, 32'h3000);
    chk("async_rst_ifid_valid", 101, {31'h0, ifid_valid}, 32'h0);
    chk("async_rst_ifid_pc", 101, ifid_pc, 32'h0);
    chk("async_rst_ifid_instr", 101, ifid_instr, 32'h0);
    chk("async_rst_ifid_bd", 101, {31'h0, ifid_bd}, 32'h0);
    chk("async_rst_im_req", 101, {31'h0, im_req}, 32'h1);
    @(negedge clk);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
